// File: rtl/arbiter_types.sv
// ---------------------------------------------------------------------------
// arbiter_types
// Shared type definitions for the I/D cache arbiter that sits between the
// two L1 caches and the cacheline adaptor.
//   arb_state_t : arbiter FSM state
//   arb_req_t   : requester identity, also used to remember the last grant
//   arb_op_t    : memory operation latched at grant time
// ---------------------------------------------------------------------------
package arbiter_types;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } arb_op_t;

    // Cachelines are 32 bytes: the low five address bits are the byte offset.
    localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Shares one cacheline memory port between the I-cache (fills only) and the
// D-cache (fills and writebacks). One transaction is open at a time; when
// both caches ask in the same idle cycle the grant alternates round-robin.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   i_read, i_addr         I-cache fill request (held until i_resp)
//   i_rdata, i_resp        I-cache fill data / one-cycle completion
//   d_read, d_write        D-cache fill / writeback request (held until d_resp)
//   d_addr, d_wdata        D-cache line address / writeback data
//   d_rdata, d_resp        D-cache fill data / one-cycle completion
//   mem_read, mem_write    memory-side request, from the latched operation
//   mem_addr, mem_wdata    memory-side address / data, from latch registers
//   mem_rdata, mem_resp    memory-side read data / completion pulse
// ---------------------------------------------------------------------------
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W-LINE_OFFSET_W){1'b1}}, {LINE_OFFSET_W{1'b0}}};

    arb_state_t        state_q, state_d;
    arb_req_t          last_q,  last_d;
    arb_op_t           op_q,    op_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic     i_act, d_act;
    arb_req_t pick;

    assign i_act = i_read;
    assign d_act = d_read | d_write;

    // Contention goes to whoever was not served last.
    always_comb begin
        pick = REQ_I;
        if (i_act && d_act) begin
            pick = (last_q == REQ_I) ? REQ_D : REQ_I;
        end else if (d_act) begin
            pick = REQ_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= REQ_I;
            op_q    <= OP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;

        case (state_q)
            ST_IDLE: begin
                // The request is captured here so later input changes cannot
                // disturb the open transaction.
                if (i_act || d_act) begin
                    if (pick == REQ_D) begin
                        state_d = ST_SERVE_D;
                        addr_d  = d_addr & LINE_MASK;
                        // A simultaneous read+write is treated as a write.
                        if (d_write) begin
                            op_d    = OP_WRITE;
                            wdata_d = d_wdata;
                        end else begin
                            op_d    = OP_READ;
                            wdata_d = '0;
                        end
                    end else begin
                        state_d = ST_SERVE_I;
                        op_d    = OP_READ;
                        addr_d  = i_addr & LINE_MASK;
                        wdata_d = '0;
                    end
                end
            end

            ST_SERVE_I: begin
                mem_read  = (op_q == OP_READ);
                mem_write = (op_q == OP_WRITE);
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = mem_rdata;
                    last_d  = REQ_I;
                    state_d = ST_DONE;
                end
            end

            ST_SERVE_D: begin
                mem_read  = (op_q == OP_READ);
                mem_write = (op_q == OP_WRITE);
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = mem_rdata;
                    last_d  = REQ_D;
                    state_d = ST_DONE;
                end
            end

            // Turnaround cycle: the served cache drops its request here, so
            // IDLE never sees a stale request from it.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Fill and writeback together is a D-cache protocol violation.
    assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
// Scoreboard bench. The stimulus task predicts, from the round-robin rule,
// the order in which requests are served and pushes the expected memory
// operation and cache response into queues. A memory model pops the memory
// queue when the DUT raises a request, and a response monitor pops the
// response queue whenever i_resp/d_resp pulses.
// ---------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct {
        bit    who;    // 0 = I-cache, 1 = D-cache
        bit    wr;
        addr_t addr;
        line_t wdata;
        line_t rdata;
        int    lat;
    } txn_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    addr_t i_addr = '0, d_addr = '0;
    line_t d_wdata = '0;
    line_t i_rdata, d_rdata, mem_wdata;
    logic  i_resp, d_resp, mem_read, mem_write;
    addr_t mem_addr;
    line_t mem_rdata;
    logic  mem_resp;

    always #5 clk = ~clk;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    txn_t mem_q[$];
    txn_t resp_q[$];
    bit   mem_hold = 1'b0;
    int   spur_cnt = 0;
    bit   model_last = 1'b0;   // last requester served; reset value is I

    function automatic line_t rnd_line();
        line_t r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string nm, input line_t act, input line_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    initial begin : mem_model
        int   spur_done;
        txn_t e;
        spur_done = 0;
        mem_resp  = 1'b0;
        mem_rdata = rnd_line();
        forever begin
            @(negedge clk);
            if (spur_done != spur_cnt) begin
                spur_done++;
                @(posedge clk); #1;
                mem_resp  = 1'b1;
                mem_rdata = rnd_line();
                @(negedge clk);
                chk("spur_i_resp", line_t'(i_resp), '0);
                chk("spur_d_resp", line_t'(d_resp), '0);
                @(posedge clk); #1;
                mem_resp = 1'b0;
                @(negedge clk);
                chk("spur_mem_idle", line_t'({mem_read, mem_write}), '0);
            end else if (!mem_hold && !rst && (mem_read || mem_write)) begin
                if (mem_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_mem_req @%0t: got rd=%b wr=%b want none",
                             $time, mem_read, mem_write);
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_op", line_t'({mem_read, mem_write}), e.wr ? 2'b01 : 2'b10);
                    chk("mem_addr", line_t'(mem_addr), line_t'(e.addr));
                    if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
                    for (int k = 0; k < e.lat; k++) begin
                        @(negedge clk);
                        chk("mem_op_hold", line_t'({mem_read, mem_write}), e.wr ? 2'b01 : 2'b10);
                        chk("mem_addr_hold", line_t'(mem_addr), line_t'(e.addr));
                        if (e.wr) chk("mem_wdata_hold", mem_wdata, e.wdata);
                    end
                    @(posedge clk); #1;
                    mem_resp  = 1'b1;
                    mem_rdata = e.rdata;
                    @(posedge clk); #1;
                    mem_resp  = 1'b0;
                    mem_rdata = rnd_line();
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : resp_mon
        bit   prev;
        txn_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (prev) chk("done_mem_idle", line_t'({mem_read, mem_write}), '0);
                prev = i_resp | d_resp;
                if (!i_resp) chk("i_rdata_zero", i_rdata, '0);
                if (!d_resp) chk("d_rdata_zero", d_rdata, '0);
                if (i_resp || d_resp) begin
                    if (resp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_resp @%0t: got i=%b d=%b want none",
                                 $time, i_resp, d_resp);
                    end else begin
                        e = resp_q.pop_front();
                        chk("resp_who", line_t'({i_resp, d_resp}), e.who ? 2'b01 : 2'b10);
                        chk("resp_rdata", e.who ? d_rdata : i_rdata, e.rdata);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input txn_t t);
        mem_q.push_back(t);
        resp_q.push_back(t);
    endtask

    task automatic round(input bit ri, input bit rd, input bit dw,
                         input addr_t ia, input addr_t da, input line_t wd,
                         input int lat_i, input int lat_d, input bit scr);
        txn_t ei, ed;
        bit   first, i_pend, d_pend, scrambled, got_i, got_d, seen_mem;
        int   guard;
        ei.who = 1'b0; ei.wr = 1'b0; ei.addr = ia & ~addr_t'(32'h1F);
        ei.wdata = '0; ei.rdata = rnd_line(); ei.lat = lat_i;
        ed.who = 1'b1; ed.wr = dw;   ed.addr = da & ~addr_t'(32'h1F);
        ed.wdata = wd; ed.rdata = rnd_line(); ed.lat = lat_d;
        // Round-robin: on contention the requester not served last goes first.
        first = (ri && rd) ? !model_last : rd;
        if (first) push_exp(ed); else push_exp(ei);
        if (ri && rd) begin
            if (first) push_exp(ei); else push_exp(ed);
            model_last = !first;
        end else begin
            model_last = first;
        end

        @(posedge clk); #1;
        i_read = ri; i_addr = ia;
        d_read = rd && !dw; d_write = rd && dw; d_addr = da; d_wdata = wd;
        i_pend = ri; d_pend = rd; scrambled = !scr; guard = 0;
        while ((i_pend || d_pend) && guard < 300) begin
            @(negedge clk);
            guard++;
            got_i = i_resp; got_d = d_resp; seen_mem = mem_read | mem_write;
            @(posedge clk); #1;
            if (got_i) begin i_pend = 1'b0; i_read = 1'b0; end
            if (got_d) begin d_pend = 1'b0; d_read = 1'b0; d_write = 1'b0; end
            // Disturb the served requester's inputs while its transaction is open.
            if (seen_mem && !scrambled) begin
                scrambled = 1'b1;
                if (first) begin d_addr = $urandom(); d_wdata = rnd_line(); end
                else i_addr = $urandom();
            end
        end
        n_cmp++;
        if (i_pend || d_pend) begin
            n_bad++;
            $display("FAIL round_timeout @%0t: got pending i=%b d=%b want none", $time, i_pend, d_pend);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin : main
        line_t pat_a;
        int    guard;
        pat_a = {8{32'hA5A5_5A5A}};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read",  line_t'(mem_read), '0);
        chk("rst_mem_write", line_t'(mem_write), '0);
        chk("rst_mem_addr",  line_t'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_i_resp",    line_t'(i_resp), '0);
        chk("rst_d_resp",    line_t'(d_resp), '0);
        chk("rst_i_rdata",   i_rdata, '0);
        chk("rst_d_rdata",   d_rdata, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b0;
        repeat (2) @(posedge clk);

        // Contention right after reset: D first, then I
        round(1, 1, 0, 32'h0000_2000, 32'h0000_3000, '0, 2, 3, 0);
        // D writeback of pattern A
        round(0, 1, 1, 32'h0, 32'h8000_0040, pat_a, 0, 4, 0);
        // I fill with unaligned address, 5-cycle memory latency
        round(1, 0, 0, 32'h0000_1234, 32'h0, '0, 5, 0, 0);
        // Three back-to-back contention rounds: D,I,D,I,D,I
        for (int r = 0; r < 3; r++)
            round(1, 1, r[0], $urandom(), $urandom(), rnd_line(),
                  $urandom_range(0, 3), $urandom_range(0, 3), 0);

        // Reset in SERVE_D before mem_resp; first make D the last grant
        round(0, 1, 1, 32'h0000_0100, 32'h0000_0200, rnd_line(), 1, 1, 0);
        mem_hold = 1'b1;
        @(posedge clk); #1;
        d_read = 1'b1; d_addr = 32'h0000_4444;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!mem_read && guard < 20);
        chk("rstmid_pre_mem_read", line_t'(mem_read), 1);
        @(posedge clk); #1;
        rst = 1'b1; d_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_mem_read", line_t'(mem_read), '0);
        chk("rstmid_mem_write", line_t'(mem_write), '0);
        chk("rstmid_d_resp", line_t'(d_resp), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid_no_reissue", line_t'({mem_read, mem_write}), '0);
        mem_hold = 1'b0;
        // last_grant must be back to I, so D wins this contention
        round(1, 1, 0, $urandom(), $urandom(), '0, 1, 2, 0);

        // Spurious mem_resp while IDLE
        @(posedge clk); #1;
        spur_cnt++;
        repeat (8) @(posedge clk);

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            int who;
            who = $urandom_range(1, 3);
            round(who[0], who[1], 1'($urandom_range(0, 1)), $urandom(), $urandom(), rnd_line(),
                  $urandom_range(0, 6), $urandom_range(0, 6), 1);
        end

        repeat (4) @(posedge clk);
        chk("mem_q_empty",  line_t'(mem_q.size()), '0);
        chk("resp_q_empty", line_t'(resp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, cacheline width in bits.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk is the only clock, and rst is sampled only on rising clk.
REQ-004 Ports SHALL be exactly:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- i_read  in  1  I-cache line fill request, held until i_resp.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  I-cache fill data.
- i_resp  out  1  I-cache completion pulse.
- d_read  in  1  D-cache line fill request, held until d_resp.
- d_write  in  1  D-cache writeback request, held until d_resp.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache writeback data.
- d_rdata  out  LINE_W  D-cache fill data.
- d_resp  out  1  D-cache completion pulse.
- mem_read  out  1  memory-side read request.
- mem_write  out  1  memory-side write request.
- mem_addr  out  ADDR_W  memory-side line address.
- mem_wdata  out  LINE_W  memory-side write data.
- mem_rdata  in  LINE_W  memory-side read data.
- mem_resp  in  1  memory-side completion pulse.

Function
REQ-005 The FSM SHALL have four states:
- IDLE: no transaction open.
- SERVE_I: I-cache transaction open.
- SERVE_D: D-cache transaction open.
- DONE: one-cycle turnaround before returning to IDLE.
REQ-006 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-007 In IDLE with exactly one requester active, that requester SHALL be granted on the next edge.
REQ-008 In IDLE with both active, the grant SHALL go to the requester opposite last_grant (round-robin).
REQ-009 On grant, the block SHALL latch into op/addr/wdata registers: the operation, the address with bits [4:0] forced to 0, and d_wdata for writes.
REQ-010 mem_read/mem_write SHALL be driven only from the latched op, only in SERVE_I/SERVE_D, and first asserted the cycle after the request is seen in IDLE.
REQ-011 mem_addr/mem_wdata SHALL come from the latched registers and SHALL be stable for the whole transaction.
REQ-012 SERVE_x with mem_resp=1 SHALL assert x_resp combinationally in the same cycle, pass mem_rdata to x_rdata, update last_grant to x, and move to DONE.
REQ-013 x_rdata SHALL be 0 whenever x_resp=0.
REQ-014 The non-granted requester's resp SHALL stay 0.
REQ-015 DONE SHALL last exactly one cycle with mem_read=mem_write=0, then go to IDLE, so the requester can deassert and is never double-served.
REQ-016 mem_resp in IDLE or DONE SHALL be ignored.
REQ-017 d_read and d_write both asserted is illegal: it SHALL trigger a simulation assertion and be treated as a write.
REQ-018 Requester inputs changing while a transaction is open SHALL NOT affect the open transaction.

Reset
REQ-019 On rst: state=IDLE, last_grant=I (so D wins the first contention), latched op/addr/wdata=0, and all outputs=0 from the following cycle.
REQ-020 rst asserted mid-transaction SHALL abandon the transaction with no resp pulse, and SHALL NOT issue a new memory request until a fresh grant.

Structure
REQ-021 The state enum (arb_state_t) and requester enum (arb_req_t) SHALL live in shared package arbiter_types, alongside rv32i_types.
REQ-022 The block SHALL be a single module with no sub-module; the FSM and the latch registers are in one file.
REQ-023 The block SHALL sit between the I/D caches and the cacheline adaptor, outside datapath.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- i_read only, i_addr=0x0000_1234, mem_resp after 5 cycles -> mem_addr=0x0000_1220; i_resp pulses 1 cycle carrying mem_rdata; d_resp stays 0.
- i_read and d_read both asserted after reset -> D served first, then DONE, then I served; mem_read low during DONE.
- d_write, d_addr=0x8000_0040, d_wdata=pattern A -> mem_write=1, mem_wdata=A; mem_read=0 throughout.
- Back-to-back contention, 3 rounds with both requesters always asserted -> grants strictly alternate D,I,D,I,D,I.
- rst raised in SERVE_D before mem_resp -> no d_resp; mem_read=0 the next cycle; last_grant=I.
- mem_resp pulsed while IDLE -> no resp on either requester; state unchanged.
